// File: rtl/farm_car_detector.sv
// -----------------------------------------------------------------------------
// farm_car_detector
//
// Counts cars queued on the farm road from a bouncy inductive loop and raises
// the car-waiting request for the traffic light controller.  The loop signal is
// synchronised, debounced and edge-detected to form arrivals; every
// SERVE_CYCLES cycles of farm green count as one departure.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a loop level change (2..15)
//   SERVE_CYCLES     green cycles counted as one departing car (1..255)
//   MAX_CARS         car_count saturation value (1..15)
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous active-low reset
//   loop_raw    in   asynchronous loop detector level (1 = metal present)
//   light_farm  in   farm lamp one-hot {red,yellow,green}; only 3'b001 is green
//   c           out  registered car-waiting request (car_count != 0)
//   car_count   out  registered queued-car count
//   overflow    out  sticky flag: an arrival was lost to saturation
// -----------------------------------------------------------------------------
module farm_car_detector #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned SERVE_CYCLES    = 8,
   parameter int unsigned MAX_CARS        = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       loop_raw,
   input  logic [2:0] light_farm,
   output logic       c,
   output logic [3:0] car_count,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAITING = 2'd1,
      SERVING = 2'd2
   } state_t;

   localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] SERVE_LAST = 8'(SERVE_CYCLES - 1);
   localparam logic [3:0] COUNT_MAX  = 4'(MAX_CARS);

   // registered state
   logic       sync1_r;
   logic       sync2_r;
   logic       deb_r;
   logic       deb_prev_r;
   logic [3:0] deb_cnt_r;
   logic [7:0] serve_tmr_r;
   logic [3:0] count_r;
   logic       c_r;
   logic       overflow_r;
   state_t     state_r;

   // next-state / combinational signals
   logic       deb_nxt_s;
   logic [3:0] deb_cnt_nxt_s;
   logic       arrival_s;
   logic       green_s;
   logic       departure_s;
   logic [7:0] serve_tmr_nxt_s;
   logic [3:0] count_nxt_s;
   logic       overflow_nxt_s;
   state_t     state_nxt_s;

   // Debounce: count consecutive cycles where the synchronised level disagrees
   // with the accepted level; flip once the full window has been seen.
   always_comb begin
      deb_nxt_s     = deb_r;
      deb_cnt_nxt_s = 4'd0;
      if (sync2_r != deb_r) begin
         if (deb_cnt_r == DEB_LAST) begin
            deb_nxt_s     = ~deb_r;
            deb_cnt_nxt_s = 4'd0;
         end else begin
            deb_nxt_s     = deb_r;
            deb_cnt_nxt_s = deb_cnt_r + 4'd1;
         end
      end else begin
         deb_nxt_s     = deb_r;
         deb_cnt_nxt_s = 4'd0;
      end
   end

   // Serve timer and queue count.  Green is judged on the live lamp input so
   // the timer counts from the very first green edge (the FSM enters SERVING
   // on that same edge); invalid lamp codes are simply "not green".
   always_comb begin
      arrival_s       = deb_r & ~deb_prev_r;
      green_s         = (light_farm == 3'b001);
      departure_s     = 1'b0;
      serve_tmr_nxt_s = 8'd0;
      count_nxt_s     = count_r;
      overflow_nxt_s  = overflow_r;

      if (green_s) begin
         if (serve_tmr_r == SERVE_LAST) begin
            departure_s     = 1'b1;
            serve_tmr_nxt_s = 8'd0;
         end else begin
            departure_s     = 1'b0;
            serve_tmr_nxt_s = serve_tmr_r + 8'd1;
         end
      end else begin
         departure_s     = 1'b0;
         serve_tmr_nxt_s = 8'd0;
      end

      // A coincident arrival and departure cancel, even at the limits.
      case ({arrival_s, departure_s})
         2'b10: begin
            if (count_r == COUNT_MAX) begin
               count_nxt_s    = count_r;
               overflow_nxt_s = 1'b1;
            end else begin
               count_nxt_s    = count_r + 4'd1;
               overflow_nxt_s = overflow_r;
            end
         end
         2'b01: begin
            if (count_r != 4'd0) begin
               count_nxt_s = count_r - 4'd1;
            end else begin
               count_nxt_s = 4'd0;
            end
         end
         default: begin
            count_nxt_s    = count_r;
            overflow_nxt_s = overflow_r;
         end
      endcase
   end

   // FSM next state: green always wins, otherwise the queue count decides.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (green_s) begin
               state_nxt_s = SERVING;
            end else if (count_nxt_s != 4'd0) begin
               state_nxt_s = WAITING;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAITING: begin
            if (green_s) begin
               state_nxt_s = SERVING;
            end else if (count_nxt_s == 4'd0) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAITING;
            end
         end
         SERVING: begin
            if (green_s) begin
               state_nxt_s = SERVING;
            end else if (count_nxt_s != 4'd0) begin
               state_nxt_s = WAITING;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // All state registers, with synchronous active-low reset taking priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_r     <= 1'b0;
         sync2_r     <= 1'b0;
         deb_r       <= 1'b0;
         deb_prev_r  <= 1'b0;
         deb_cnt_r   <= 4'd0;
         serve_tmr_r <= 8'd0;
         count_r     <= 4'd0;
         c_r         <= 1'b0;
         overflow_r  <= 1'b0;
         state_r     <= IDLE;
      end else begin
         sync1_r     <= loop_raw;
         sync2_r     <= sync1_r;
         deb_r       <= deb_nxt_s;
         deb_prev_r  <= deb_r;
         deb_cnt_r   <= deb_cnt_nxt_s;
         serve_tmr_r <= serve_tmr_nxt_s;
         count_r     <= count_nxt_s;
         c_r         <= (count_nxt_s != 4'd0);
         overflow_r  <= overflow_nxt_s;
         state_r     <= state_nxt_s;
      end
   end

   assign c         = c_r;
   assign car_count = count_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_farm_car_detector.sv
// -----------------------------------------------------------------------------
// tb_farm_car_detector
//
// Directed self-checking bench for farm_car_detector with default parameters
// (DEBOUNCE_CYCLES=4, SERVE_CYCLES=8, MAX_CARS=15).  Inputs are driven and
// outputs sampled 1 time unit after each rising edge; expected values are
// hand-derived from the edge numbering of the detector's latency.
// -----------------------------------------------------------------------------
module tb_farm_car_detector;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   logic       clk;
   logic       rst_n;
   logic       loop_raw;
   logic [2:0] light_farm;
   logic       c;
   logic [3:0] car_count;
   logic       overflow;

   int checks;
   int errors;

   farm_car_detector #(
      .DEBOUNCE_CYCLES(4),
      .SERVE_CYCLES   (8),
      .MAX_CARS       (15)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .loop_raw  (loop_raw),
      .light_farm(light_farm),
      .c         (c),
      .car_count (car_count),
      .overflow  (overflow)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check, reports any mismatch.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit past the last edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Hold reset for two edges with quiet inputs; caller releases it.
   task automatic do_reset();
      rst_n      = 1'b0;
      loop_raw   = 1'b0;
      light_farm = RED;
      tick(2);
   endtask

   // One clean car: loop high 6 cycles then low 6 cycles.  The count updates
   // on the 7th edge (first low edge); deb falls again on the last low edge.
   task automatic arrive();
      loop_raw = 1'b1;
      tick(6);
      loop_raw = 1'b0;
      tick(6);
   endtask

   // Release reset together with a held-high loop and check the 7-edge latency.
   task automatic latency_check(input string tag);
      rst_n      = 1'b1;
      light_farm = RED;
      loop_raw   = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick(1);
         check_eq({tag, "_count"}, 32'(car_count), (e >= 7) ? 32'd1 : 32'd0);
         check_eq({tag, "_c"},     32'(c),         (e >= 7) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      loop_raw   = 1'b0;
      light_farm = RED;

      // Reset state
      do_reset();
      check_eq("rst_count", 32'(car_count), 32'd0);
      check_eq("rst_c",     32'(c),         32'd0);
      check_eq("rst_ovf",   32'(overflow),  32'd0);

      // Held-high loop: first car after exactly 7 edges
      latency_check("lat");
      loop_raw = 1'b0;
      tick(10);
      check_eq("fall_no_event", 32'(car_count), 32'd1);

      // Invalid and yellow lamp codes are not green: no departures
      light_farm = 3'b011;
      tick(20);
      check_eq("invalid_light", 32'(car_count), 32'd1);
      light_farm = YELLOW;
      tick(20);
      check_eq("yellow_light", 32'(car_count), 32'd1);
      light_farm = 3'b111;
      tick(20);
      check_eq("all_on_light", 32'(car_count), 32'd1);
      light_farm = RED;

      // Bounce: 3 highs then toggling never debounces
      do_reset();
      rst_n    = 1'b1;
      loop_raw = 1'b1;
      tick(3);
      for (int i = 0; i < 20; i++) begin
         loop_raw = ~loop_raw;
         tick(1);
         check_eq("bounce_count", 32'(car_count), 32'd0);
      end
      loop_raw = 1'b0;
      tick(10);
      check_eq("bounce_end_count", 32'(car_count), 32'd0);
      check_eq("bounce_end_c",     32'(c),         32'd0);

      // Three cars then green drains one per 8 green edges
      do_reset();
      rst_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         arrive();
         check_eq("arr3_count", 32'(car_count), 32'(i));
      end
      tick(4);
      light_farm = GREEN;
      for (int g = 1; g <= 30; g++) begin
         tick(1);
         check_eq("drain_count", 32'(car_count),
                  (g < 8) ? 32'd3 : (g < 16) ? 32'd2 : (g < 24) ? 32'd1 : 32'd0);
         check_eq("drain_c", 32'(c), (g < 24) ? 32'd1 : 32'd0);
      end
      light_farm = RED;
      tick(2);

      // Arrival coincident with a departure leaves the count unchanged
      do_reset();
      rst_n = 1'b1;
      arrive();
      check_eq("coin_pre_count", 32'(car_count), 32'd1);
      tick(4);
      light_farm = GREEN;
      tick(1);
      loop_raw = 1'b1;
      for (int g = 2; g <= 16; g++) begin
         tick(1);
         check_eq("coin_count", 32'(car_count), (g < 16) ? 32'd1 : 32'd0);
         check_eq("coin_c",     32'(c),         (g < 16) ? 32'd1 : 32'd0);
      end
      check_eq("coin_ovf", 32'(overflow), 32'd0);
      loop_raw   = 1'b0;
      light_farm = RED;
      tick(10);

      // Saturation at 15 and sticky overflow
      do_reset();
      rst_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         arrive();
         check_eq("sat_count", 32'(car_count), (i >= 15) ? 32'd15 : 32'(i));
         check_eq("sat_ovf",   32'(overflow),  (i >= 16) ? 32'd1 : 32'd0);
      end
      light_farm = GREEN;
      tick(119);
      check_eq("sat_drain_pre", 32'(car_count), 32'd1);
      tick(1);
      check_eq("sat_drain_count", 32'(car_count), 32'd0);
      check_eq("sat_drain_c",     32'(c),         32'd0);
      tick(10);
      check_eq("no_underflow",    32'(car_count), 32'd0);
      check_eq("sat_drain_ovf",   32'(overflow),  32'd1);
      light_farm = RED;
      tick(2);

      // Reset mid-serve discards everything, including overflow
      for (int i = 1; i <= 5; i++) begin
         arrive();
      end
      check_eq("pre_rst_count", 32'(car_count), 32'd5);
      check_eq("pre_rst_ovf",   32'(overflow),  32'd1);
      light_farm = GREEN;
      tick(3);
      check_eq("mid_serve_count", 32'(car_count), 32'd5);
      rst_n = 1'b0;
      tick(1);
      check_eq("midrst_count", 32'(car_count), 32'd0);
      check_eq("midrst_c",     32'(c),         32'd0);
      check_eq("midrst_ovf",   32'(overflow),  32'd0);
      latency_check("relat");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/farm_car_detector.md
FARM_CAR_DETECTOR -- requirements
Module: farm_car_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable cycles (range 2..15) needed to accept a loop level change.
REQ-002 Parameter SERVE_CYCLES, default 8, SHALL set the green-light cycles (range 1..255) counted as one car departing.
REQ-003 Parameter MAX_CARS, default 15, SHALL set the car_count saturation value (range 1..15).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-006 loop_raw  input  1  SHALL carry the asynchronous, bouncy farm-road inductive loop signal (1 = metal present).
REQ-007 light_farm  input  3  SHALL carry the controller's farm lamp state, one-hot {red,yellow,green}: 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-008 c  output  1  SHALL be the car-waiting request into traffic_light (1 = at least one farm car queued).
REQ-009 car_count  output  4  SHALL be the current queued-car count.
REQ-010 overflow  output  1  SHALL be a sticky flag set when an arrival is lost to saturation.

Function
REQ-011 loop_raw SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-012 Debounce: internal level deb SHALL flip only after sync2 differs from deb for DEBOUNCE_CYCLES consecutive edges; any edge with sync2 == deb SHALL zero the debounce counter.
REQ-013 Arrival SHALL be a one-cycle pulse, deb high and registered previous deb low; falling deb SHALL generate no event.
REQ-014 Latency: numbering edge 1 as the first edge sampling loop_raw high, with loop_raw held high, deb SHALL rise at edge DEBOUNCE_CYCLES+2 and c/car_count SHALL update at edge DEBOUNCE_CYCLES+3 (7 for default).
REQ-015 A loop_raw high pulse yielding fewer than DEBOUNCE_CYCLES consecutive high sync2 cycles SHALL produce no arrival.
REQ-016 FSM states: IDLE (car_count==0, not green), WAITING (car_count>0, not green), SERVING (light_farm==3'b001).
REQ-017 Transitions: any state -> SERVING when light_farm==3'b001; SERVING -> WAITING or IDLE by car_count when light_farm!=3'b001; IDLE <-> WAITING by car_count.
REQ-018 In SERVING, an 8-bit serve timer SHALL count edges; on reaching SERVE_CYCLES-1 it SHALL reload to 0 and issue a departure.
REQ-019 Serve timer SHALL be 0 whenever not in SERVING, so each green period starts a fresh SERVE_CYCLES window.
REQ-020 Departure with car_count==0 SHALL leave car_count at 0 (no underflow).
REQ-021 Arrival with car_count==MAX_CARS SHALL leave car_count unchanged and set overflow.
REQ-022 Simultaneous arrival and departure SHALL leave car_count unchanged, including at 0 and MAX_CARS, and SHALL NOT set overflow.
REQ-023 c SHALL be registered, equal to (next car_count != 0), and change on the same edge as car_count.
REQ-024 Any light_farm value other than 3'b001, including invalid codes, SHALL be treated as not green.

Reset
REQ-025 rst_n low at a rising edge SHALL take priority over all events and set sync1, sync2, deb, prev deb, debounce counter, serve timer, car_count to 0, c to 0, overflow to 0, FSM to IDLE.
REQ-026 Reset mid-debounce or mid-serve SHALL discard partial progress; after release, a held-high loop_raw SHALL again need the full REQ-014 latency.
REQ-027 Outputs SHALL be defined (0) from the first edge with rst_n low; there is no asynchronous path.

Verification (defaults D=4, SERVE=8, MAX=15)
REQ-028 Reset, then loop_raw held high from edge 1, light red -> c and car_count=1 at edge 7, never before.
REQ-029 loop_raw high for 3 cycles, then toggled every cycle for 20 cycles, light red -> car_count stays 0, c stays 0.
REQ-030 3 clean arrivals (each high 6, low 6), then light_farm=3'b001 for 30 cycles -> car_count 3->2->1->0 at green edges 8, 16, 24; c falls at edge 24.
REQ-031 16 clean arrivals with light red -> car_count saturates at 15, overflow=1 after the 16th arrival; overflow remains 1 after a later green drains the count to 0.
REQ-032 car_count=1, green, arrival pulse aligned to the departure edge -> car_count stays 1, c stays 1.
REQ-033 car_count=5 in SERVING, rst_n low for 1 edge -> car_count=0, c=0, overflow=0; the next arrival again needs the full 7-edge latency.
